lives_icon_row: RTL and testbench

LIVES_ICON_ROW -- requirements
Module: lives_icon_row

---
 rtl/lives_icon_row_pkg.sv | 17 +
 rtl/lives_icon_row_if.sv | 22 ++
 rtl/lives_icon_row_rom.sv | 62 ++++++
 rtl/lives_icon_row.sv | 190 +++++++++++++++++++
 tb/tb_lives_icon_row.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/lives_icon_row_pkg.sv
// Shared types and elaboration-time helpers for the lives icon row.
package icon_row_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BLINK = 1'b1
  } state_t;

  function automatic int addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

  function automatic int slot_pitch(input int w, input int gap);
    return w + gap;
  endfunction

endpackage

// File: rtl/lives_icon_row_if.sv
// Pixel-scan inputs and registered colour outputs of the lives icon row.
interface lives_icon_row_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       frame_start;
  logic [3:0] lives;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       lives_on;
  logic       blinking;

  modport master (
    output DrawX, DrawY, frame_start, lives,
    input  red, green, blue, lives_on, blinking
  );

  modport slave (
    input  DrawX, DrawY, frame_start, lives,
    output red, green, blue, lives_on, blinking
  );
endinterface

// File: rtl/lives_icon_row_rom.sv
// Sprite ROM with a registered 1-cycle read, followed by a 4-entry palette.
module icon_rom
  import icon_row_pkg::*;
#(
  parameter  int ICON_W = 34,
  parameter  int ICON_H = 16,
  localparam int AW     = addr_w(ICON_W, ICON_H)
) (
  input  logic          vga_clk,
  input  logic          Reset,
  input  logic [AW-1:0] addr,
  output logic [1:0]    idx,
  output logic [3:0]    red,
  output logic [3:0]    green,
  output logic [3:0]    blue
);

  localparam int DEPTH = ICON_W * ICON_H;

  // Top and bottom rows are transparent; the interior cycles through 3 colours diagonally.
  function automatic logic [1:0] sprite_px(input int a);
    int lx;
    int ly;
    lx = a % ICON_W;
    ly = a / ICON_W;
    if (ly == 0 || ly == ICON_H - 1) return 2'd0;
    return 2'(1 + ((lx + ly) % 3));
  endfunction

  logic [1:0] rom_tbl [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom_tbl[a] = sprite_px(a);
  end

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      idx <= 2'd0;
    end else if ({1'b0, addr} < (AW + 1)'(DEPTH)) begin
      idx <= rom_tbl[addr];
    end else begin
      idx <= 2'd0;
    end
  end

  always_comb begin
    red   = 4'h0;
    green = 4'h0;
    blue  = 4'h0;
    case (idx)
      2'd1: red = 4'hF;
      2'd2: begin
        red   = 4'hF;
        green = 4'h8;
        blue  = 4'h8;
      end
      2'd3: red = 4'h8;
      default: ;
    endcase
  end

endmodule

// File: rtl/lives_icon_row.sv
// Row of life icons on the VGA scan, with a blink animation for lost lives.
module lives_icon_row
  import icon_row_pkg::*;
#(
  parameter int NUM_ICONS    = 4,
  parameter int ICON_W       = 34,
  parameter int ICON_H       = 16,
  parameter int ORIGIN_X     = 52,
  parameter int ORIGIN_Y     = 425,
  parameter int SPACING      = 0,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 8
) (
  input  logic             vga_clk,
  input  logic             Reset,
  lives_icon_row_if.slave  bus
);

  localparam int PITCH = slot_pitch(ICON_W, SPACING);
  localparam int AW    = addr_w(ICON_W, ICON_H);
  localparam int FCW   = $clog2(BLINK_FRAMES + 1);
  localparam int PCW   = $clog2(BLINK_PERIOD + 1);

  state_t         state, state_n;
  logic [3:0]     shown, shown_n;
  logic [3:0]     lo, lo_n;
  logic [3:0]     hi, hi_n;
  logic [FCW-1:0] frame_cnt, frame_cnt_n;
  logic [PCW-1:0] ph_cnt, ph_cnt_n;
  logic           blink_phase, blink_phase_n;
  logic [3:0]     sat;

  assign sat = (bus.lives > 4'(NUM_ICONS)) ? 4'(NUM_ICONS) : bus.lives;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state       <= IDLE;
      shown       <= 4'd0;
      lo          <= 4'd0;
      hi          <= 4'd0;
      frame_cnt   <= '0;
      ph_cnt      <= '0;
      blink_phase <= 1'b0;
    end else begin
      state       <= state_n;
      shown       <= shown_n;
      lo          <= lo_n;
      hi          <= hi_n;
      frame_cnt   <= frame_cnt_n;
      ph_cnt      <= ph_cnt_n;
      blink_phase <= blink_phase_n;
    end
  end

  always_comb begin
    state_n       = state;
    shown_n       = shown;
    lo_n          = lo;
    hi_n          = hi;
    frame_cnt_n   = frame_cnt;
    ph_cnt_n      = ph_cnt;
    blink_phase_n = blink_phase;
    if (bus.frame_start) begin
      case (state)
        IDLE: begin
          if (sat < shown) begin
            lo_n          = sat;
            hi_n          = shown;
            shown_n       = sat;
            frame_cnt_n   = '0;
            ph_cnt_n      = '0;
            blink_phase_n = 1'b1;
            state_n       = BLINK;
          end else begin
            shown_n = sat;
          end
        end
        BLINK: begin
          if (sat < shown) begin
            // Further loss widens the range downward; hi keeps the original top.
            lo_n          = sat;
            shown_n       = sat;
            frame_cnt_n   = '0;
            ph_cnt_n      = '0;
            blink_phase_n = 1'b1;
          end else if (sat > shown || frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
            shown_n       = sat;
            lo_n          = 4'd0;
            hi_n          = 4'd0;
            frame_cnt_n   = '0;
            ph_cnt_n      = '0;
            blink_phase_n = 1'b0;
            state_n       = IDLE;
          end else begin
            frame_cnt_n = frame_cnt + 1'b1;
            if (ph_cnt == PCW'(BLINK_PERIOD - 1)) begin
              ph_cnt_n      = '0;
              blink_phase_n = ~blink_phase;
            end else begin
              ph_cnt_n = ph_cnt + 1'b1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.blinking = (state == BLINK);

  // Slot decode: offsets are only formed once the range compare has matched.
  logic [15:0]   dx, dy, off_x, off_y;
  logic          hit_c;
  logic [2:0]    slot_c;
  logic [AW-1:0] addr_c;

  always_comb begin
    dx     = {6'd0, bus.DrawX};
    dy     = {6'd0, bus.DrawY};
    hit_c  = 1'b0;
    slot_c = 3'd0;
    off_x  = 16'd0;
    off_y  = 16'd0;
    if (dy >= 16'(ORIGIN_Y) && dy < 16'(ORIGIN_Y + ICON_H)) begin
      off_y = dy - 16'(ORIGIN_Y);
      for (int k = 0; k < NUM_ICONS; k++) begin
        if (dx >= 16'(ORIGIN_X + k * PITCH) && dx < 16'(ORIGIN_X + k * PITCH + ICON_W)) begin
          hit_c  = 1'b1;
          slot_c = 3'(k);
          off_x  = dx - 16'(ORIGIN_X + k * PITCH);
        end
      end
    end
    addr_c = AW'(off_y * 16'(ICON_W) + off_x);
  end

  // Stage 1: hit flag, slot index and sprite address
  logic          hit_p0;
  logic [2:0]    slot_p0;
  logic [AW-1:0] addr_p0;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      hit_p0  <= 1'b0;
      slot_p0 <= 3'd0;
      addr_p0 <= '0;
    end else begin
      hit_p0  <= hit_c;
      slot_p0 <= slot_c;
      addr_p0 <= addr_c;
    end
  end

  function automatic logic slot_visible(input logic [3:0] s, input logic [3:0] shw,
                                        input logic [3:0] l, input logic [3:0] h,
                                        input logic ph);
    return (s < shw) || (ph && s >= l && s < h);
  endfunction

  // Stage 2: ROM read, palette, output register
  logic       vld_p1;
  logic [1:0] idx_p1;
  logic [3:0] rom_r, rom_g, rom_b;

  always_ff @(posedge vga_clk) begin
    if (Reset) vld_p1 <= 1'b0;
    else       vld_p1 <= hit_p0 && slot_visible({1'b0, slot_p0}, shown, lo, hi, blink_phase);
  end

  icon_rom #(
    .ICON_W (ICON_W),
    .ICON_H (ICON_H)
  ) u_rom (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .addr    (addr_p0),
    .idx     (idx_p1),
    .red     (rom_r),
    .green   (rom_g),
    .blue    (rom_b)
  );

  logic pix_on;
  assign pix_on       = vld_p1 && (idx_p1 != 2'd0);
  assign bus.lives_on = pix_on;
  assign bus.red      = pix_on ? rom_r : 4'h0;
  assign bus.green    = pix_on ? rom_g : 4'h0;
  assign bus.blue     = pix_on ? rom_b : 4'h0;

endmodule

// File: tb/tb_lives_icon_row.sv
// Directed bench for lives_icon_row at default parameters.
module tb_lives_icon_row;

  logic vga_clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 vga_clk = ~vga_clk;

  lives_icon_row_if bus();

  lives_icon_row dut (
    .vga_clk (vga_clk),
    .Reset   (Reset),
    .bus     (bus)
  );

  logic [11:0] rgb;
  assign rgb = {bus.red, bus.green, bus.blue};

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] lv);
    bus.lives       = lv;
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic probe(input int x, input int y);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    tick();
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.frame_start = 1'b0; bus.lives = 4'd0;
    tick(); tick();
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL reset_on: got %b want 0", bus.lives_on); end
    vectors++; if (rgb !== 12'h000) begin miscompares++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    vectors++; if (bus.blinking !== 1'b0) begin miscompares++; $display("FAIL reset_blink: got %b want 0", bus.blinking); end
    Reset = 1'b0;
    probe(60, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL reset_shown0: got %b want 0", bus.lives_on); end
  endtask

  task automatic test_basic();
    frame(4'd3);
    probe(0, 0);
    bus.DrawX = 10'd60; bus.DrawY = 10'd430;
    tick();
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL latency_1cyc: got %b want 0", bus.lives_on); end
    tick();
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL latency_2cyc: got %b want 1", bus.lives_on); end
    vectors++; if (rgb !== 12'hF88) begin miscompares++; $display("FAIL rgb_addr178: got %h want F88", rgb); end
    probe(61, 430);
    vectors++; if (rgb !== 12'h800) begin miscompares++; $display("FAIL rgb_idx3: got %h want 800", rgb); end
    probe(62, 430);
    vectors++; if (rgb !== 12'hF00) begin miscompares++; $display("FAIL rgb_idx1: got %h want F00", rgb); end
  endtask

  task automatic test_transparent();
    probe(52, 425);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL transp_on: got %b want 0", bus.lives_on); end
    vectors++; if (rgb !== 12'h000) begin miscompares++; $display("FAIL transp_rgb: got %h want 000", rgb); end
    probe(52, 440);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL transp_bottom: got %b want 0", bus.lives_on); end
  endtask

  task automatic test_slot_bounds();
    probe(154, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL slot3_hidden: got %b want 0", bus.lives_on); end
    bus.lives = 4'd4;
    probe(154, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL no_frame_update: got %b want 0", bus.lives_on); end
    frame(4'd4);
    probe(154, 430);
    vectors++; if (bus.lives_on !== 1'b1 || rgb !== 12'h800) begin miscompares++; $display("FAIL slot3_shown: got %b/%h want 1/800", bus.lives_on, rgb); end
    probe(153, 430);
    vectors++; if (bus.lives_on !== 1'b1 || rgb !== 12'h800) begin miscompares++; $display("FAIL slot2_lastcol: got %b/%h want 1/800", bus.lives_on, rgb); end
    probe(52, 424);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL above_row: got %b want 0", bus.lives_on); end
    probe(52, 439);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL row14: got %b want 1", bus.lives_on); end
    probe(52, 441);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL below_row: got %b want 0", bus.lives_on); end
  endtask

  task automatic test_saturate();
    frame(4'd15);
    probe(187, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL sat_slot3_end: got %b want 1", bus.lives_on); end
    probe(188, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL sat_past_row: got %b want 0", bus.lives_on); end
    probe(51, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL left_of_row: got %b want 0", bus.lives_on); end
    probe(1023, 1023);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL far_corner: got %b want 0", bus.lives_on); end
  endtask

  task automatic test_blink();
    frame(4'd2);
    vectors++; if (bus.blinking !== 1'b1) begin miscompares++; $display("FAIL blink_start: got %b want 1", bus.blinking); end
    probe(128, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL blink_f0_s2: got %b want 1", bus.lives_on); end
    for (int i = 1; i <= 59; i++) begin
      frame(4'd2);
      if (i == 7 || i == 16) begin
        probe(162, 430);
        vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL blink_f%0d_s3: got %b want 1", i, bus.lives_on); end
      end
      if (i == 8 || i == 15) begin
        probe(128, 430);
        vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL blink_f%0d_s2: got %b want 0", i, bus.lives_on); end
        probe(94, 430);
        vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL blink_f%0d_s1: got %b want 1", i, bus.lives_on); end
      end
      if (i == 59) begin
        vectors++; if (bus.blinking !== 1'b1) begin miscompares++; $display("FAIL blink_f59: got %b want 1", bus.blinking); end
      end
    end
    frame(4'd2);
    vectors++; if (bus.blinking !== 1'b0) begin miscompares++; $display("FAIL blink_end: got %b want 0", bus.blinking); end
    probe(128, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL end_s2: got %b want 0", bus.lives_on); end
    probe(162, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL end_s3: got %b want 0", bus.lives_on); end
  endtask

  task automatic test_redecrease();
    frame(4'd4);
    frame(4'd2);
    for (int i = 0; i < 3; i++) frame(4'd2);
    frame(4'd1);
    vectors++; if (bus.blinking !== 1'b1) begin miscompares++; $display("FAIL redec_blink: got %b want 1", bus.blinking); end
    probe(94, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL redec_s1_f0: got %b want 1", bus.lives_on); end
    for (int i = 0; i < 5; i++) frame(4'd1);
    probe(94, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL redec_restart_f5: got %b want 1", bus.lives_on); end
    for (int i = 0; i < 3; i++) frame(4'd1);
    probe(94, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL redec_s1_f8: got %b want 0", bus.lives_on); end
    probe(162, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL redec_s3_f8: got %b want 0", bus.lives_on); end
    probe(60, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL redec_s0_f8: got %b want 1", bus.lives_on); end
    frame(4'd3);
    vectors++; if (bus.blinking !== 1'b0) begin miscompares++; $display("FAIL abort_blink: got %b want 0", bus.blinking); end
    probe(128, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL abort_s2: got %b want 1", bus.lives_on); end
    probe(162, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL abort_s3: got %b want 0", bus.lives_on); end
  endtask

  task automatic test_reset_mid_blink();
    frame(4'd1);
    vectors++; if (bus.blinking !== 1'b1) begin miscompares++; $display("FAIL pre_reset_blink: got %b want 1", bus.blinking); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    vectors++; if (bus.blinking !== 1'b0) begin miscompares++; $display("FAIL rst_mid_blink: got %b want 0", bus.blinking); end
    probe(60, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL rst_mid_s0: got %b want 0", bus.lives_on); end
    probe(128, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL rst_mid_s2: got %b want 0", bus.lives_on); end
    frame(4'd1);
    vectors++; if (bus.blinking !== 1'b0) begin miscompares++; $display("FAIL rst_first_frame_blink: got %b want 0", bus.blinking); end
    probe(60, 430);
    vectors++; if (bus.lives_on !== 1'b1) begin miscompares++; $display("FAIL rst_first_frame_s0: got %b want 1", bus.lives_on); end
    probe(94, 430);
    vectors++; if (bus.lives_on !== 1'b0) begin miscompares++; $display("FAIL rst_first_frame_s1: got %b want 0", bus.lives_on); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_transparent();
    test_slot_bounds();
    test_saturate();
    test_blink();
    test_redecrease();
    test_reset_mid_blink();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
